// File: rtl/cpu_pkg.sv
// Shared pipeline definitions for the 5-stage core: datapath widths and the
// MEM/WB bundle layout used by the pipeline registers and the WB stage.
package cpu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic                      hit;
    logic [DATA_WIDTH-1:0]     readData;
    logic [DATA_WIDTH-1:0]     ALUResult;
    logic [REG_ADDR_WIDTH-1:0] writeReg;
    logic                      RegWrite;
    logic                      MemtoReg;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop: async active-low clear, flush loads zeros (wins over
// stall), stall holds, otherwise loads d_i.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (flush_i) begin
      data_d = '0;
    end else if (!stall_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: one-cycle capture of memory-stage results for the
// write-back stage, with stall (hold) and flush (bubble) support.
module mem_wb_register
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      hit,
  input  logic [DATA_WIDTH-1:0]     readData,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic [REG_ADDR_WIDTH-1:0] writeReg,
  input  logic                      RegWrite,
  input  logic                      MemtoReg,
  output logic                      hitOut,
  output logic [DATA_WIDTH-1:0]     readDataOut,
  output logic [DATA_WIDTH-1:0]     ALUResultOut,
  output logic [REG_ADDR_WIDTH-1:0] writeRegOut,
  output logic                      RegWriteOut,
  output logic                      MemtoRegOut
);

  // Flat bundle so the widths follow the module parameters, not the package.
  localparam int BUNDLE_W = 2 * DATA_WIDTH + REG_ADDR_WIDTH + 3;

  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_q;

  assign bundle_d = {hit, readData, ALUResult, writeReg, RegWrite, MemtoReg};

  pipe_reg #(
    .WIDTH(BUNDLE_W)
  ) u_pipe_reg (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .stall_i(Stall),
    .flush_i(Flush),
    .d_i    (bundle_d),
    .q_o    (bundle_q)
  );

  assign {hitOut, readDataOut, ALUResultOut, writeRegOut, RegWriteOut, MemtoRegOut} = bundle_q;

endmodule

// File: tb/tb_mem_wb_register.sv
// Directed + randomized bench for mem_wb_register against a priority-rule model.
module tb_mem_wb_register;

  logic        CLK;
  logic        RST_N;
  logic        Stall;
  logic        Flush;
  logic        hit;
  logic [31:0] readData;
  logic [31:0] ALUResult;
  logic [4:0]  writeReg;
  logic        RegWrite;
  logic        MemtoReg;
  logic        hitOut;
  logic [31:0] readDataOut;
  logic [31:0] ALUResultOut;
  logic [4:0]  writeRegOut;
  logic        RegWriteOut;
  logic        MemtoRegOut;

  // Reference model state: what the WB stage should currently see.
  logic        m_hit;
  logic [31:0] m_readData;
  logic [31:0] m_ALUResult;
  logic [4:0]  m_writeReg;
  logic        m_RegWrite;
  logic        m_MemtoReg;

  int checks   = 0;
  int failures = 0;

  mem_wb_register dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Stall       (Stall),
    .Flush       (Flush),
    .hit         (hit),
    .readData    (readData),
    .ALUResult   (ALUResult),
    .writeReg    (writeReg),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .hitOut      (hitOut),
    .readDataOut (readDataOut),
    .ALUResultOut(ALUResultOut),
    .writeRegOut (writeRegOut),
    .RegWriteOut (RegWriteOut),
    .MemtoRegOut (MemtoRegOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".hitOut"},       {31'd0, hitOut},      {31'd0, m_hit});
    chk({tag, ".readDataOut"},  readDataOut,          m_readData);
    chk({tag, ".ALUResultOut"}, ALUResultOut,         m_ALUResult);
    chk({tag, ".writeRegOut"},  {27'd0, writeRegOut}, {27'd0, m_writeReg});
    chk({tag, ".RegWriteOut"},  {31'd0, RegWriteOut}, {31'd0, m_RegWrite});
    chk({tag, ".MemtoRegOut"},  {31'd0, MemtoRegOut}, {31'd0, m_MemtoReg});
  endtask

  task automatic model_clear();
    m_hit = 1'b0; m_readData = '0; m_ALUResult = '0;
    m_writeReg = '0; m_RegWrite = 1'b0; m_MemtoReg = 1'b0;
  endtask

  // One rising edge with the given controls; model follows reset > flush > stall > load.
  task automatic step(input logic st, input logic fl, input string tag);
    Stall = st;
    Flush = fl;
    if (!RST_N) begin
      model_clear();
    end else if (fl) begin
      model_clear();
    end else if (!st) begin
      m_hit = hit; m_readData = readData; m_ALUResult = ALUResult;
      m_writeReg = writeReg; m_RegWrite = RegWrite; m_MemtoReg = MemtoReg;
    end
    @(posedge CLK);
    #1;
    chk_all(tag);
  endtask

  task automatic rand_in();
    hit       = 1'($urandom);
    readData  = $urandom;
    ALUResult = $urandom;
    writeReg  = 5'($urandom);
    RegWrite  = 1'($urandom);
    MemtoReg  = 1'($urandom);
  endtask

  task automatic set_in(input logic h, input logic [31:0] rd, input logic [31:0] alu,
                        input logic [4:0] wr, input logic rw, input logic m2r);
    hit = h; readData = rd; ALUResult = alu; writeReg = wr; RegWrite = rw; MemtoReg = m2r;
  endtask

  initial begin
    RST_N = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    model_clear();
    set_in(1'b1, 32'hA5A5_A5A5, 32'h1234_5678, 5'd17, 1'b1, 1'b1);

    // Reset held with non-zero inputs across several edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "reset_hold");

    // Release reset away from an edge; nothing captured before the first edge.
    @(negedge CLK);
    RST_N = 1'b1;
    set_in(1'b1, 32'd14, 32'd7, 5'd1, 1'b0, 1'b1);
    #1;
    chk_all("pre_first_edge");
    step(1'b0, 1'b0, "basic_load");
    chk("basic_readData_14", readDataOut, 32'd14);

    // Back-to-back loads.
    for (int i = 0; i < 5; i++) begin
      rand_in();
      ALUResult = 32'd8 + 32'(i);
      step(1'b0, 1'b0, "back_to_back");
    end

    // Stall holds through input changes.
    set_in(1'b0, 32'h0000_0042, 32'd7, 5'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, "stall_preload");
    set_in(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, "stall_hold");
      chk("stall_ALUResult_7", ALUResultOut, 32'd7);
    end
    step(1'b0, 1'b0, "stall_release");

    // Flush beats stall.
    set_in(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 5'd5, 1'b1, 1'b1);
    step(1'b0, 1'b0, "flush_preload");
    step(1'b1, 1'b1, "flush_with_stall");
    chk("flush_RegWriteOut_0", {31'd0, RegWriteOut}, 32'd0);

    // Width boundary: every bit set.
    set_in(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1);
    step(1'b0, 1'b0, "all_ones");
    set_in(1'b0, 32'h8000_0001, 32'h0000_0000, 5'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, "r0_passthrough");

    // Randomized controls and data.
    for (int i = 0; i < 200; i++) begin
      rand_in();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), "random");
    end

    // Asynchronous reset mid-cycle, then recovery.
    set_in(1'b1, 32'hCAFE_F00D, 32'h0BAD_F00D, 5'd9, 1'b1, 1'b1);
    step(1'b0, 1'b0, "async_preload");
    #2;
    RST_N = 1'b0;
    model_clear();
    #1;
    chk_all("async_reset_immediate");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_in();
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), "post_reset_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_register.md
Name: mem_wb_register

Overview:
- MEM/WB pipeline register of the 5-stage MIPS-style core; sits between the data-memory stage and the write-back mux.
- Captures the memory read data, ALU result, destination register index, the write-back control bits (RegWrite, MemtoReg) and the data-cache hit flag on each rising clock edge.
- Presents the captured values to the WB stage one cycle later.
- Supports hold (stall) and bubble insertion (flush) for hazard/cache-miss handling.

Parameters:
- DATA_WIDTH, 32, width of readData/ALUResult paths.
- REG_ADDR_WIDTH, 5, width of the destination register index.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- Stall  input  1  when 1, register holds its current contents.
- Flush  input  1  when 1, register loads a bubble (all zeros).
- hit  input  1  data-cache hit flag from MEM stage.
- readData  input  DATA_WIDTH  data read from memory.
- ALUResult  input  DATA_WIDTH  ALU result / memory address from MEM stage.
- writeReg  input  REG_ADDR_WIDTH  destination register index.
- RegWrite  input  1  register-file write enable for this instruction.
- MemtoReg  input  1  WB mux select: 1 = readData, 0 = ALUResult.
- hitOut  output  1  registered hit.
- readDataOut  output  DATA_WIDTH  registered readData.
- ALUResultOut  output  DATA_WIDTH  registered ALUResult.
- writeRegOut  output  REG_ADDR_WIDTH  registered writeReg.
- RegWriteOut  output  1  registered RegWrite.
- MemtoRegOut  output  1  registered MemtoReg.

Behaviour:
- One clock; reset is asynchronous and active-low (CLK, RST_N).
- Reset: while RST_N=0 every output is 0, regardless of CLK. Outputs change immediately on RST_N falling, not at the next edge.
- After RST_N deasserts, the first rising CLK edge is the first capture.
- Each output is driven directly from a flop; no combinational path from any input to any output.
- Latency: exactly one cycle. A value presented before rising edge N appears on the outputs after edge N and stays stable until the next update.
- Priority at each rising edge: RST_N low > Flush > Stall > normal load.
- Flush=1: all outputs go to 0 (RegWriteOut=0 guarantees no architectural write), even if Stall=1 in the same cycle.
- Stall=1, Flush=0: all outputs hold their previous values, and input changes are ignored.
- Normal load (Stall=0, Flush=0): every output takes its corresponding input. No width conversion; the full DATA_WIDTH and REG_ADDR_WIDTH bits are copied unmodified.
- writeReg=0 passes through unchanged; suppressing writes to r0 is the register file's job.
- Inputs that are X/Z are captured as-is; there is no sanitisation except under reset or flush.
- No internal state beyond the output flops.

Decomposition:
- Shared package (cpu_pkg): DATA_WIDTH=32, REG_ADDR_WIDTH=5, and a packed struct mem_wb_t {hit, readData, ALUResult, writeReg, RegWrite, MemtoReg} reused by the other pipeline registers and the WB stage.
- One natural sub-module: pipe_reg, a generic WIDTH-parameterised flop with async active-low reset, flush-to-zero and hold.
- mem_wb_register instantiates pipe_reg once over the packed struct (or per field) and unpacks the result to the named output ports.

Test Plan:
- Reset: hold RST_N=0 with non-zero inputs over several edges -> all outputs 0; assert RST_N mid-cycle after loading -> outputs clear immediately, without waiting for a clock edge.
- Basic load: hit=1, readData=32'd14, ALUResult=32'd7, writeReg=5'd1, RegWrite=0, MemtoReg=1, Stall=Flush=0.
  - Before the first rising edge, outputs are still 0.
  - After the first rising edge: hitOut=1, readDataOut=14, ALUResultOut=7, writeRegOut=1, RegWriteOut=0, MemtoRegOut=1.
- Back-to-back: change inputs every cycle (ALUResult 7, 8, 9 ...) -> each value appears exactly one edge later, with no skipped or duplicated entries.
- Stall: load ALUResult=7, then Stall=1 while inputs change to ALUResult=32'hFFFF_FFFF, writeReg=31 for 3 edges -> outputs remain 7/1; after Stall=0, the next edge loads the new values.
- Flush: load RegWrite=1, writeReg=5, readData=32'hDEAD_BEEF, then Flush=1 together with Stall=1 -> after the edge all outputs are 0, including RegWriteOut.
- Width boundary: readData=ALUResult=32'hFFFF_FFFF, writeReg=5'd31 -> outputs show all-ones in every bit, with no truncation.
